// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : risc_pkg
//  Description : Opcodes, FSM state type and instruction field helpers for
//                the parametrised multi-cycle RISC core.
//  Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_BZ   = 4'hA;
    localparam logic [3:0] OP_BNZ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_OUT  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_ILL  = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    // Helpers take the instruction zero-extended to a fixed container so
    // they work for any RA_W/DATA_W combination; callers truncate the result.
    localparam int unsigned FIELD_MAX_W = 64;
    typedef logic [FIELD_MAX_W-1:0] field_t;

    function automatic logic [3:0] instr_op(input field_t instr,
                                            input int unsigned ra_w,
                                            input int unsigned data_w);
        return 4'(instr >> (2 * ra_w + data_w));
    endfunction

    function automatic field_t instr_rd(input field_t instr,
                                        input int unsigned ra_w,
                                        input int unsigned data_w);
        return (instr >> (ra_w + data_w)) & ((field_t'(1) << ra_w) - field_t'(1));
    endfunction

    function automatic field_t instr_rs(input field_t instr,
                                        input int unsigned ra_w,
                                        input int unsigned data_w);
        return (instr >> data_w) & ((field_t'(1) << ra_w) - field_t'(1));
    endfunction

    function automatic field_t instr_imm(input field_t instr,
                                         input int unsigned data_w);
        return instr & ((field_t'(1) << data_w) - field_t'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/risc_core_param_if.sv
`default_nettype none
// ============================================================================
//  Interface   : risc_core_param_if
//  Description : Instruction-memory req/ack fetch channel.
//  Revision    : 1.0 - initial release
// ============================================================================
interface risc_core_param_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface
`default_nettype wire

// File: rtl/risc_alu.sv
`default_nettype none
// ============================================================================
//  Module      : risc_alu
//  Description : Combinational ALU for arithmetic, logic and shift opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module risc_alu
    import risc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  wire logic [DATA_W-1:0] a,
    input  wire logic [DATA_W-1:0] b,
    input  wire logic [3:0]        op,
    output logic      [DATA_W-1:0] result,
    output logic                   carry,
    output logic                   zero
);

    always_comb begin
        result = a;
        carry  = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                result = a - b;
                carry  = (b > a);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[DATA_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: ;
        endcase
    end

    assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/risc_core_param.sv
`default_nettype none
// ============================================================================
//  Module      : risc_core_param
//  Description : Parametrised two-state (fetch/exec) RISC core with req/ack
//                instruction fetch, Z/C flags and an OUT register.
//  Revision    : 1.0 - initial release
// ============================================================================
module risc_core_param
    import risc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int PC_W   = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    risc_core_param_if.master      imem,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    output logic                   zero_flag,
    output logic                   carry_flag,
    output logic                   halted,
    output logic                   illegal
);

    localparam int unsigned RA_W    = $clog2(NREGS);
    localparam int unsigned INSTR_W = 4 + 2 * RA_W + DATA_W;

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_regs [NREGS];

    logic [3:0]          w_op;
    logic [RA_W-1:0]     w_rd;
    logic [RA_W-1:0]     w_rs;
    logic [DATA_W-1:0]   w_imm;
    logic [DATA_W-1:0]   w_rd_val;
    logic [DATA_W-1:0]   w_rs_val;
    logic [DATA_W-1:0]   w_alu_b;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_carry;
    logic                w_alu_zero;
    logic [PC_W-1:0]     w_target;
    logic [PC_W-1:0]     w_pc_inc;

    assign w_op     = instr_op(field_t'(r_ir), RA_W, DATA_W);
    assign w_rd     = RA_W'(instr_rd(field_t'(r_ir), RA_W, DATA_W));
    assign w_rs     = RA_W'(instr_rs(field_t'(r_ir), RA_W, DATA_W));
    assign w_imm    = DATA_W'(instr_imm(field_t'(r_ir), DATA_W));
    assign w_rd_val = r_regs[w_rd];
    assign w_rs_val = r_regs[w_rs];
    assign w_alu_b  = (w_op == OP_ADDI) ? w_imm : w_rs_val;
    assign w_pc_inc = r_pc + PC_W'(1);

    generate
        if (PC_W > DATA_W) begin : g_tgt_zext
            assign w_target = {{(PC_W - DATA_W){1'b0}}, w_imm};
        end else begin : g_tgt_slice
            assign w_target = w_imm[PC_W-1:0];
        end
    endgenerate

    risc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (w_rd_val),
        .b      (w_alu_b),
        .op     (w_op),
        .result (w_alu_res),
        .carry  (w_alu_carry),
        .zero   (w_alu_zero)
    );

    // Gated by reset so an in-flight request is withdrawn the moment reset rises.
    assign imem.imem_req  = (r_state == FETCH) && !reset;
    assign imem.imem_addr = r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH;
            r_pc       <= '0;
            r_ir       <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                FETCH: begin
                    if (imem.imem_ack) begin
                        r_ir    <= imem.imem_data;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_state <= FETCH;
                    r_pc    <= w_pc_inc;
                    case (w_op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                        OP_ADDI, OP_SHL, OP_SHR: begin
                            r_regs[w_rd] <= w_alu_res;
                            zero_flag    <= w_alu_zero;
                            carry_flag   <= w_alu_carry;
                        end
                        OP_LDI:  r_regs[w_rd] <= w_imm;
                        OP_BZ:   if (zero_flag)  r_pc <= w_target;
                        OP_BNZ:  if (!zero_flag) r_pc <= w_target;
                        OP_JMP:  r_pc <= w_target;
                        OP_OUT: begin
                            out_data  <= w_rd_val;
                            out_valid <= 1'b1;
                        end
                        OP_HALT: begin
                            r_state <= HALT;
                            halted  <= 1'b1;
                        end
                        OP_ILL: begin
                            illegal <= 1'b1;
                            r_state <= HALT;
                            halted  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                HALT:    ;
                default: r_state <= FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire
